mult_reservation_station: RTL and testbench
===========================================

# mult_reservation_station

Issue-side front end for the 4-stage pipelined multiplier. Holds up to ENTRIES pending multiply operations, renames unavailable operands to producer tags, and snoops the common data bus (CDB) to capture operands. Dispatches one ready entry per cycle as operand pair plus tag into the multiplier. Releases an entry when the multiplier's result for its tag is broadcast on the CDB.

## Interface
- ENTRIES, 4, number of station entries (2..8)
- DATA_WIDTH, 32, operand/result width
- TAG_WIDTH, 6, tag width; tag value 0 is reserved as "no tag / no operation"
- BASE_TAG, 8, tag of entry i is BASE_TAG+i; BASE_TAG must be nonzero and BASE_TAG+ENTRIES-1 < 2^TAG_WIDTH
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous clear of all entries (mispredict)
- issue_valid  in  1  new multiply offered
- issue_ready  out  1  at least one entry free
- issue_tag  out  TAG_WIDTH  tag the offered op will receive (lowest free entry); 0 when full
- issue_src1_tag, issue_src2_tag  in  TAG_WIDTH  producer tag; 0 means the data field is valid
- issue_src1_data, issue_src2_data  in  DATA_WIDTH  operand values, used when tag is 0
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_WIDTH  broadcast tag
- cdb_data  in  DATA_WIDTH  broadcast value
- mul_op1, mul_op2  out  DATA_WIDTH  registered operands to multiplier
- mul_tag  out  TAG_WIDTH  registered tag to multiplier; 0 = bubble

## Operation
- Entry state: busy, dispatched, per-source {tag, data}. A source is ready when its tag is 0.
- Issue: accepted on an edge where issue_valid && issue_ready. Writes the lowest-index free entry. busy=1, dispatched=0.
- Issue bypass: if issue_srcN_tag != 0 and cdb_valid && cdb_tag == issue_srcN_tag in the same cycle, store cdb_data with tag 0.
- Snoop: every busy entry whose source tag equals cdb_tag with cdb_valid captures cdb_data and clears that tag.
- Dispatch: each cycle, select the lowest-index entry with busy && !dispatched && both sources ready, evaluated on registered state only. Drive its data and tag onto mul_* at the next edge and set dispatched=1. With no candidate, mul_tag <= 0 and mul_op1/mul_op2 <= 0.
- Release: busy entry with dispatched=1 and cdb_valid && cdb_tag == own tag clears busy at that edge. A CDB match on an undispatched entry's own tag is ignored.
- issue_ready and issue_tag are combinational from registered busy bits. A release and a new issue to the same entry on the same edge is not allowed: the freed slot is offered from the next cycle.
- Tags 0 on cdb_tag never match any source.
- flush or reset: all entries cleared, mul_* <= 0 on that edge. flush has priority over issue, snoop and dispatch in that cycle. reset has priority over flush.

## Timing
- Reset values: issue_ready=1, issue_tag=BASE_TAG, mul_op1=0, mul_op2=0, mul_tag=0, all entries free.
- Issue at edge n with both sources ready: dispatch on mul_* after edge n+1. Minimum issue-to-dispatch latency is 1 cycle.
- An operand captured from the CDB at edge n makes the entry eligible for dispatch at edge n+1.
- Throughput: 1 dispatch per cycle. With the 4-stage multiplier, a result returns tagged 4 edges after dispatch. The entry stays busy until the CDB broadcast.
- Full: with ENTRIES busy, issue_ready=0 and issue_tag=0. An issue_valid in that cycle is ignored.

## Structure
- Shared package: TAG_WIDTH, NO_TAG=0, DATA_WIDTH defaults, and the rs_entry_t struct {busy, dispatched, src1_tag, src1_data, src2_tag, src2_data}. The package is reused by the ALU station and the CDB arbiter.
- One sub-module, rs_entry: a single entry's storage, snoop, bypass and release logic, instantiated ENTRIES times by a generate loop. The top level holds the free/ready priority encoders and the output register.

## Test plan
- Reset, then issue src1=(0,7), src2=(0,6): issue_tag=8. After 2 edges, mul_op1=7, mul_op2=6, mul_tag=8. On the following cycle mul_tag=0.
- Issue src1 tag 20 / src2 ready 3. Hold 3 cycles: no dispatch. CDB {20,5}: dispatch 5×3, tag 8, one edge later.
- Issue with src1_tag=20 while cdb_valid, cdb_tag=20, data 9 in the same cycle: stored as 9. Dispatch after 1 cycle.
- Fill 4 entries: issue_ready=0, issue_tag=0, and an extra issue is dropped. CDB {9} after entry 1 dispatched: entry 1 freed, and the next cycle issue_tag=9.
- Two entries become ready on the same edge: entry 0 dispatches first, entry 1 on the next cycle.
- Assert flush with 3 busy entries and one dispatch pending: next cycle mul_tag=0, issue_ready=1, issue_tag=8, and no later dispatch of the flushed ops.

Source files
------------

// File: rtl/mult_reservation_station_pkg.sv
// Shared reservation-station types and helpers, reused by the ALU station and CDB arbiter.
package mult_reservation_station_pkg;

  localparam int TAG_WIDTH  = 6;
  localparam int DATA_WIDTH = 32;
  localparam logic [TAG_WIDTH-1:0] NO_TAG = 6'd0;

  typedef struct packed {
    logic                  busy;
    logic                  dispatched;
    logic [TAG_WIDTH-1:0]  src1_tag;
    logic [DATA_WIDTH-1:0] src1_data;
    logic [TAG_WIDTH-1:0]  src2_tag;
    logic [DATA_WIDTH-1:0] src2_data;
  } rs_entry_t;

  // A zero broadcast tag never matches, so ready sources are never overwritten.
  function automatic logic tag_hit(input logic                 valid,
                                   input logic [TAG_WIDTH-1:0] bus_tag,
                                   input logic [TAG_WIDTH-1:0] want_tag);
    return valid && (bus_tag != NO_TAG) && (bus_tag == want_tag);
  endfunction

endpackage

// File: rtl/mult_reservation_station_if.sv
// Issue, CDB and multiplier-feed signals of the multiply reservation station.
interface mult_reservation_station_if;
  import mult_reservation_station_pkg::*;

  logic                  issue_valid;
  logic                  issue_ready;
  logic [TAG_WIDTH-1:0]  issue_tag;
  logic [TAG_WIDTH-1:0]  issue_src1_tag;
  logic [DATA_WIDTH-1:0] issue_src1_data;
  logic [TAG_WIDTH-1:0]  issue_src2_tag;
  logic [DATA_WIDTH-1:0] issue_src2_data;
  logic                  cdb_valid;
  logic [TAG_WIDTH-1:0]  cdb_tag;
  logic [DATA_WIDTH-1:0] cdb_data;
  logic [DATA_WIDTH-1:0] mul_op1;
  logic [DATA_WIDTH-1:0] mul_op2;
  logic [TAG_WIDTH-1:0]  mul_tag;

  modport master (
    output issue_valid, issue_src1_tag, issue_src1_data, issue_src2_tag, issue_src2_data,
    output cdb_valid, cdb_tag, cdb_data,
    input  issue_ready, issue_tag, mul_op1, mul_op2, mul_tag
  );

  modport slave (
    input  issue_valid, issue_src1_tag, issue_src1_data, issue_src2_tag, issue_src2_data,
    input  cdb_valid, cdb_tag, cdb_data,
    output issue_ready, issue_tag, mul_op1, mul_op2, mul_tag
  );

endinterface

// File: rtl/mult_reservation_station_rs_entry.sv
// One station entry: issue write with CDB bypass, operand snoop, dispatch mark and release.
module rs_entry
  import mult_reservation_station_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [TAG_WIDTH-1:0]  own_tag,
  input  logic                  issue_we,
  input  logic [TAG_WIDTH-1:0]  src1_tag,
  input  logic [DATA_WIDTH-1:0] src1_data,
  input  logic [TAG_WIDTH-1:0]  src2_tag,
  input  logic [DATA_WIDTH-1:0] src2_data,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  input  logic                  dispatch_sel,
  output rs_entry_t             state
);

  rs_entry_t state_r;
  rs_entry_t next_s;

  // Next entry contents from issue, snoop, dispatch and release.
  always_comb begin
    next_s = state_r;
    if (issue_we) begin
      next_s.busy       = 1'b1;
      next_s.dispatched = 1'b0;
      next_s.src1_tag   = tag_hit(cdb_valid, cdb_tag, src1_tag) ? NO_TAG : src1_tag;
      next_s.src1_data  = tag_hit(cdb_valid, cdb_tag, src1_tag) ? cdb_data : src1_data;
      next_s.src2_tag   = tag_hit(cdb_valid, cdb_tag, src2_tag) ? NO_TAG : src2_tag;
      next_s.src2_data  = tag_hit(cdb_valid, cdb_tag, src2_tag) ? cdb_data : src2_data;
    end else if (state_r.busy) begin
      if (tag_hit(cdb_valid, cdb_tag, state_r.src1_tag)) begin
        next_s.src1_tag  = NO_TAG;
        next_s.src1_data = cdb_data;
      end else begin
        next_s.src1_tag  = state_r.src1_tag;
      end
      if (tag_hit(cdb_valid, cdb_tag, state_r.src2_tag)) begin
        next_s.src2_tag  = NO_TAG;
        next_s.src2_data = cdb_data;
      end else begin
        next_s.src2_tag  = state_r.src2_tag;
      end
      if (dispatch_sel) begin
        next_s.dispatched = 1'b1;
      end else begin
        next_s.dispatched = state_r.dispatched;
      end
      // Own-tag broadcasts only release after dispatch; before that they are someone else's echo.
      if (state_r.dispatched && tag_hit(cdb_valid, cdb_tag, own_tag)) begin
        next_s = '0;
      end else begin
        next_s.busy = 1'b1;
      end
    end else begin
      next_s = state_r;
    end
  end

  // Entry storage; reset outranks flush, flush outranks everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= '0;
    end else if (flush) begin
      state_r <= '0;
    end else begin
      state_r <= next_s;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/mult_reservation_station.sv
// Multiply reservation station: free/ready priority encoders, entry array and multiplier feed register.
module mult_reservation_station
  import mult_reservation_station_pkg::*;
#(
  parameter int ENTRIES  = 4,
  parameter int BASE_TAG = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  mult_reservation_station_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  rs_entry_t          entry_s [ENTRIES];
  logic [ENTRIES-1:0] busy_vec_s;
  logic [ENTRIES-1:0] cand_vec_s;
  logic [ENTRIES-1:0] free_vec_s;
  logic [ENTRIES-1:0] free_oh_s;
  logic [ENTRIES-1:0] cand_oh_s;
  logic [ENTRIES-1:0] issue_we_s;
  logic [IDX_W-1:0]   free_idx_s;
  logic [IDX_W-1:0]   cand_idx_s;
  logic               accept_s;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    rs_entry u_entry (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .own_tag      (TAG_WIDTH'(BASE_TAG + i)),
      .issue_we     (issue_we_s[i]),
      .src1_tag     (bus.issue_src1_tag),
      .src1_data    (bus.issue_src1_data),
      .src2_tag     (bus.issue_src2_tag),
      .src2_data    (bus.issue_src2_data),
      .cdb_valid    (bus.cdb_valid),
      .cdb_tag      (bus.cdb_tag),
      .cdb_data     (bus.cdb_data),
      .dispatch_sel (cand_oh_s[i]),
      .state        (entry_s[i])
    );
    assign busy_vec_s[i] = entry_s[i].busy;
    assign cand_vec_s[i] = entry_s[i].busy && !entry_s[i].dispatched &&
                           (entry_s[i].src1_tag == NO_TAG) && (entry_s[i].src2_tag == NO_TAG);
  end

  // Isolate the lowest set bit of each request vector.
  assign free_vec_s = ~busy_vec_s;
  assign free_oh_s  = free_vec_s & (~free_vec_s + ENTRIES'(1));
  assign cand_oh_s  = cand_vec_s & (~cand_vec_s + ENTRIES'(1));

  // One-hot to index encoders for the free slot and the dispatch candidate.
  always_comb begin
    free_idx_s = '0;
    cand_idx_s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      free_idx_s = free_idx_s | (free_oh_s[i] ? IDX_W'(i) : IDX_W'(0));
      cand_idx_s = cand_idx_s | (cand_oh_s[i] ? IDX_W'(i) : IDX_W'(0));
    end
  end

  assign bus.issue_ready = |free_vec_s;
  assign bus.issue_tag   = bus.issue_ready ? (TAG_WIDTH'(BASE_TAG) + TAG_WIDTH'(free_idx_s)) : NO_TAG;
  assign accept_s        = bus.issue_valid && bus.issue_ready;
  assign issue_we_s      = free_oh_s & {ENTRIES{accept_s}};

  // Multiplier feed register; zero tag marks a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mul_op1 <= '0;
      bus.mul_op2 <= '0;
      bus.mul_tag <= NO_TAG;
    end else if (flush) begin
      bus.mul_op1 <= '0;
      bus.mul_op2 <= '0;
      bus.mul_tag <= NO_TAG;
    end else if (|cand_vec_s) begin
      bus.mul_op1 <= entry_s[cand_idx_s].src1_data;
      bus.mul_op2 <= entry_s[cand_idx_s].src2_data;
      bus.mul_tag <= TAG_WIDTH'(BASE_TAG) + TAG_WIDTH'(cand_idx_s);
    end else begin
      bus.mul_op1 <= '0;
      bus.mul_op2 <= '0;
      bus.mul_tag <= NO_TAG;
    end
  end

endmodule

// File: tb/tb_mult_reservation_station.sv
// Directed bench for mult_reservation_station with hand-computed expectations.
module tb_mult_reservation_station;

  logic clk;
  logic reset;
  logic flush;
  int   n_checks;
  int   n_errors;

  mult_reservation_station_if bus ();

  mult_reservation_station #(.ENTRIES(4), .BASE_TAG(8)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic v, input logic [5:0] t1, input logic [31:0] d1,
                             input logic [5:0] t2, input logic [31:0] d2);
    bus.issue_valid     = v;
    bus.issue_src1_tag  = t1;
    bus.issue_src1_data = d1;
    bus.issue_src2_tag  = t2;
    bus.issue_src2_data = d2;
  endtask

  task automatic drive_cdb(input logic v, input logic [5:0] t, input logic [31:0] d);
    bus.cdb_valid = v;
    bus.cdb_tag   = t;
    bus.cdb_data  = d;
  endtask

  task automatic check_mul(input string tag, input logic [31:0] op1, input logic [31:0] op2,
                           input logic [5:0] t);
    check_eq({tag, "_op1"}, 64'(bus.mul_op1), 64'(op1));
    check_eq({tag, "_op2"}, 64'(bus.mul_op2), 64'(op2));
    check_eq({tag, "_tag"}, 64'(bus.mul_tag), 64'(t));
  endtask

  task automatic release_tag(input logic [5:0] t);
    drive_cdb(1'b1, t, 32'd0);
    tick();
    drive_cdb(1'b0, 6'd0, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    flush = 1'b0;
    drive_issue(1'b0, 6'd0, 32'd0, 6'd0, 32'd0);
    drive_cdb(1'b0, 6'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_ready", 64'(bus.issue_ready), 64'd1);
    check_eq("rst_tag", 64'(bus.issue_tag), 64'd8);
    check_mul("rst_mul", 32'd0, 32'd0, 6'd0);

    // Ready operands dispatch after two edges, then a bubble
    drive_issue(1'b1, 6'd0, 32'd7, 6'd0, 32'd6);
    check_eq("t1_issue_tag", 64'(bus.issue_tag), 64'd8);
    tick();
    drive_issue(1'b0, 6'd0, 32'd0, 6'd0, 32'd0);
    check_eq("t1_next_tag", 64'(bus.issue_tag), 64'd9);
    check_eq("t1_no_early", 64'(bus.mul_tag), 64'd0);
    tick();
    check_mul("t1_disp", 32'd7, 32'd6, 6'd8);
    tick();
    check_eq("t1_bubble", 64'(bus.mul_tag), 64'd0);
    release_tag(6'd8);
    check_eq("t1_freed", 64'(bus.issue_tag), 64'd8);

    // Operand waits on tag 20, captured from CDB
    drive_issue(1'b1, 6'd20, 32'd0, 6'd0, 32'd3);
    tick();
    drive_issue(1'b0, 6'd0, 32'd0, 6'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t2_wait", 64'(bus.mul_tag), 64'd0);
    end
    drive_cdb(1'b1, 6'd20, 32'd5);
    tick();
    drive_cdb(1'b0, 6'd0, 32'd0);
    check_eq("t2_capture_edge", 64'(bus.mul_tag), 64'd0);
    tick();
    check_mul("t2_disp", 32'd5, 32'd3, 6'd8);
    release_tag(6'd8);

    // Issue-time bypass from the CDB
    drive_issue(1'b1, 6'd20, 32'd0, 6'd0, 32'd4);
    drive_cdb(1'b1, 6'd20, 32'd9);
    tick();
    drive_issue(1'b0, 6'd0, 32'd0, 6'd0, 32'd0);
    drive_cdb(1'b0, 6'd0, 32'd0);
    tick();
    check_mul("t3_bypass", 32'd9, 32'd4, 6'd8);
    release_tag(6'd8);

    // Fill all four entries, back-to-back dispatch, full behaviour
    for (int i = 0; i < 4; i++) begin
      drive_issue(1'b1, 6'd0, 32'(i + 1), 6'd0, 32'(i + 1));
      check_eq("t4_issue_tag", 64'(bus.issue_tag), 64'(8 + i));
      tick();
      if (i > 0) check_eq("t4_pipe_tag", 64'(bus.mul_tag), 64'(7 + i));
      else       check_eq("t4_pipe_tag", 64'(bus.mul_tag), 64'd0);
    end
    check_eq("t4_full_ready", 64'(bus.issue_ready), 64'd0);
    check_eq("t4_full_tag", 64'(bus.issue_tag), 64'd0);
    drive_issue(1'b1, 6'd0, 32'd55, 6'd0, 32'd55);
    tick();
    check_mul("t4_last_disp", 32'd4, 32'd4, 6'd11);
    drive_issue(1'b0, 6'd0, 32'd0, 6'd0, 32'd0);
    tick();
    check_eq("t4_drop", 64'(bus.mul_tag), 64'd0);
    check_eq("t4_still_full", 64'(bus.issue_ready), 64'd0);
    release_tag(6'd9);
    check_eq("t4_rel_ready", 64'(bus.issue_ready), 64'd1);
    check_eq("t4_rel_tag", 64'(bus.issue_tag), 64'd9);
    check_eq("t4_no_extra", 64'(bus.mul_tag), 64'd0);
    release_tag(6'd8);
    release_tag(6'd10);
    release_tag(6'd11);
    check_eq("t4_empty_tag", 64'(bus.issue_tag), 64'd8);

    // Undispatched own-tag broadcast is ignored
    drive_issue(1'b1, 6'd33, 32'd0, 6'd0, 32'd1);
    tick();
    drive_issue(1'b0, 6'd0, 32'd0, 6'd0, 32'd0);
    release_tag(6'd8);
    check_eq("t4b_keep", 64'(bus.issue_tag), 64'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Two entries become ready on the same edge
    drive_issue(1'b1, 6'd30, 32'd0, 6'd0, 32'd2);
    tick();
    drive_issue(1'b1, 6'd30, 32'd0, 6'd0, 32'd3);
    tick();
    drive_issue(1'b0, 6'd0, 32'd0, 6'd0, 32'd0);
    drive_cdb(1'b1, 6'd30, 32'd10);
    tick();
    drive_cdb(1'b0, 6'd0, 32'd0);
    check_eq("t5_capture_edge", 64'(bus.mul_tag), 64'd0);
    tick();
    check_mul("t5_first", 32'd10, 32'd2, 6'd8);
    tick();
    check_mul("t5_second", 32'd10, 32'd3, 6'd9);
    tick();
    check_eq("t5_bubble", 64'(bus.mul_tag), 64'd0);
    release_tag(6'd8);
    release_tag(6'd9);

    // Flush with three busy entries and one dispatch pending
    drive_issue(1'b1, 6'd40, 32'd0, 6'd0, 32'd1);
    tick();
    drive_issue(1'b1, 6'd40, 32'd0, 6'd0, 32'd2);
    tick();
    drive_issue(1'b1, 6'd0, 32'd6, 6'd0, 32'd7);
    tick();
    drive_issue(1'b0, 6'd0, 32'd0, 6'd0, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_mul("t6_flush", 32'd0, 32'd0, 6'd0);
    check_eq("t6_ready", 64'(bus.issue_ready), 64'd1);
    check_eq("t6_tag", 64'(bus.issue_tag), 64'd8);
    drive_cdb(1'b1, 6'd40, 32'd77);
    tick();
    drive_cdb(1'b0, 6'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t6_no_ghost", 64'(bus.mul_tag), 64'd0);
    end
    check_eq("t6_tag_after", 64'(bus.issue_tag), 64'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
